// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I core: byte-enabled word array with
// 1-cycle registered loads, sign/zero extension and a sticky access-error flag.
module dmem_responder #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_op,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        hold,
    output logic [31:0] mem_rdata,
    output logic        access_err,
    output logic [31:0] err_addr
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_err_addr;

    logic          w_rst;
    logic [AW-1:0] w_idx;
    logic          w_is_store;
    logic          w_is_load;
    logic          w_store_ok;
    logic          w_load_ok;
    logic          w_fault;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;
    logic          w_unused_hi;

    function automatic logic load_legal(input logic [2:0] op, input logic [1:0] lo);
        logic ok;
        case (op)
            OP_B, OP_BU: ok = 1'b1;
            OP_H, OP_HU: ok = ~lo[0];
            OP_W:        ok = (lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic store_legal(input logic [2:0] op, input logic [1:0] lo);
        logic ok;
        case (op)
            OP_B:    ok = 1'b1;
            OP_H:    ok = ~lo[0];
            OP_W:    ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  op);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_B:    res = {{24{b[7]}}, b};
            OP_H:    res = {{16{h[15]}}, h};
            OP_W:    res = word;
            OP_BU:   res = {24'h000000, b};
            OP_HU:   res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // reset_n is active-high despite its name
    assign w_rst       = reset_n;
    assign w_idx       = mem_addr[AW+1:2];
    assign w_unused_hi = ^mem_addr[31:AW+2];
    assign w_is_store  = mem_write;
    assign w_is_load   = mem_to_reg & ~mem_write;
    assign w_store_ok  = store_legal(mem_op, mem_addr[1:0]);
    assign w_load_ok   = load_legal(mem_op, mem_addr[1:0]);
    assign w_fault     = (w_is_store & ~w_store_ok) | (w_is_load & ~w_load_ok);

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = 32'h0000_0000;
        if (w_is_store && w_store_ok && !w_rst) begin
            case (mem_op)
                OP_B: begin
                    w_be     = 4'b0001 << mem_addr[1:0];
                    w_wlanes = {4{mem_wdata[7:0]}};
                end
                OP_H: begin
                    w_be     = mem_addr[1] ? 4'b1100 : 4'b0011;
                    w_wlanes = {2{mem_wdata[15:0]}};
                end
                OP_W: begin
                    w_be     = 4'b1111;
                    w_wlanes = mem_wdata;
                end
                default: begin
                    w_be     = 4'b0000;
                    w_wlanes = 32'h0000_0000;
                end
            endcase
        end else begin
            w_be     = 4'b0000;
            w_wlanes = 32'h0000_0000;
        end
    end

    // Byte-enabled array write; stores still land during hold since they are idempotent
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                r_mem[w_idx][i*8 +: 8] <= w_wlanes[i*8 +: 8];
            end
        end
    end

    // Load response and sticky error capture
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_rdata    <= 32'h0000_0000;
            r_err      <= 1'b0;
            r_err_addr <= 32'h0000_0000;
        end else if (!hold) begin
            if (w_is_load) begin
                r_rdata <= w_load_ok ? load_extend(r_mem[w_idx], mem_addr[1:0], mem_op)
                                     : 32'h0000_0000;
            end
            if (w_fault) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_addr <= mem_addr;
                end
            end
        end
    end

    assign mem_rdata  = r_rdata;
    assign access_err = r_err;
    assign err_addr   = r_err_addr;

endmodule
